// File: rtl/cla_pkg.sv
// Shared constants and types for the two-stage carry-lookahead adder.
// Stage-1 fields are sized for the widest supported operand; instances use the low bits.
package cla_pkg;

    localparam int unsigned GRP_SIZE  = 2;
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_NGRP  = MAX_WIDTH / GRP_SIZE;

    function automatic int unsigned cla_ngrp(input int unsigned width);
        return width / GRP_SIZE;
    endfunction

    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic                 cin;
        logic [MAX_NGRP-1:0]  grp_g;
        logic [MAX_NGRP-1:0]  grp_p;
    } s1_data_t;

endpackage

// File: rtl/cla_grp_gp.sv
// Combinational 2-bit group generate/propagate cell.
module cla_grp_gp (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       p
);

    logic [1:0] bit_g;
    logic [1:0] bit_p;

    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
        g     = bit_g[1] | (bit_p[1] & bit_g[0]);
        p     = bit_p[1] & bit_p[0];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Stage 1 registers operands and group G/P; stage 2 resolves carries and registers the result.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_g,
    output logic             out_p
);

    localparam int unsigned NGRP = cla_ngrp(WIDTH);

    // Group carries c[0..NGRP] from group G/P and a carry-in.
    function automatic logic [NGRP:0] grp_carries(input logic [NGRP-1:0] gg,
                                                  input logic [NGRP-1:0] gp,
                                                  input logic            c_in);
        logic [NGRP:0] c;
        c[0] = c_in;
        for (int k = 0; k < NGRP; k++) begin
            c[k+1] = gg[k] | (gp[k] & c[k]);
        end
        return c;
    endfunction

    s1_data_t        s1_q;
    s1_data_t        s1_d;
    logic            s1_valid;
    logic [NGRP-1:0] in_grp_g;
    logic [NGRP-1:0] in_grp_p;
    logic            accept;
    logic            adv;

    assign adv      = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | adv;
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_grp_gp u_grp_gp (
            .a (in_a[2*k+1:2*k]),
            .b (in_b[2*k+1:2*k]),
            .g (in_grp_g[k]),
            .p (in_grp_p[k])
        );
    end

    always_comb begin
        s1_d                  = '0;
        s1_d.a[WIDTH-1:0]     = in_a;
        s1_d.b[WIDTH-1:0]     = in_b;
        s1_d.cin              = in_cin;
        s1_d.grp_g[NGRP-1:0]  = in_grp_g;
        s1_d.grp_p[NGRP-1:0]  = in_grp_p;
    end

    // Stage 2 combinational carry resolution and sum.
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [NGRP-1:0]  s2_gg;
    logic [NGRP-1:0]  s2_gp;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_c;
    logic [NGRP:0]    c_cin;
    logic [NGRP:0]    c_zero;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        s2_a   = s1_q.a[WIDTH-1:0];
        s2_b   = s1_q.b[WIDTH-1:0];
        s2_gg  = s1_q.grp_g[NGRP-1:0];
        s2_gp  = s1_q.grp_p[NGRP-1:0];
        bit_g  = s2_a & s2_b;
        bit_p  = s2_a ^ s2_b;
        c_cin  = grp_carries(s2_gg, s2_gp, s1_q.cin);
        c_zero = grp_carries(s2_gg, s2_gp, 1'b0);
        bit_c  = '0;
        for (int k = 0; k < NGRP; k++) begin
            bit_c[2*k]   = c_cin[k];
            bit_c[2*k+1] = bit_g[2*k] | (bit_p[2*k] & c_cin[k]);
        end
        sum_d = bit_p ^ bit_c;
    end

    if (WIDTH < MAX_WIDTH) begin : g_hi
        logic unused_s1_hi;
        assign unused_s1_hi = ^{s1_q.a[MAX_WIDTH-1:WIDTH], s1_q.b[MAX_WIDTH-1:WIDTH],
                                s1_q.grp_g[MAX_NGRP-1:NGRP], s1_q.grp_p[MAX_NGRP-1:NGRP]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output data only moves on adv, so it stays stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_g     <= 1'b0;
            out_p     <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_sum   <= sum_d;
            out_cout  <= c_cin[NGRP];
            out_g     <= c_zero[NGRP];
            out_p     <= &s2_gp;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
